// File: rtl/vector_store_handler.sv
// Vector store sequencer: captures a LANES-wide vector plus base address and
// writes one memory word per lane at consecutive addresses, stalling the pipeline meanwhile.
module vector_store_handler #(
    parameter int DATA_WIDTH = 16,
    parameter int LANES      = 16,
    parameter int ADDR_WIDTH = 19
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [ADDR_WIDTH-1:0]         base_addr,
    input  logic [LANES*DATA_WIDTH-1:0]   vector_in,
    input  logic                          mem_ready,
    output logic                          mem_we,
    output logic [ADDR_WIDTH-1:0]         mem_addr,
    output logic [DATA_WIDTH-1:0]         mem_wdata,
    output logic                          block_pipe,
    output logic                          done,
    output logic [1:0]                    state_dbg
);

    localparam int IDX_W = $clog2(LANES);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        STORE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                        state_q, state_d;
    logic [IDX_W-1:0]              idx_q, idx_d;
    logic [ADDR_WIDTH-1:0]         base_q, base_d;
    logic [LANES*DATA_WIDTH-1:0]   vec_q, vec_d;

    logic [DATA_WIDTH-1:0]         lane_arr [LANES];
    logic [IDX_W-1:0]              lane_sel;

    for (genvar g = 0; g < LANES; g++) begin : g_lanes
        assign lane_arr[g] = vec_q[g*DATA_WIDTH +: DATA_WIDTH];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            base_q  <= '0;
            vec_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            base_q  <= base_d;
            vec_q   <= vec_d;
        end
    end

    // Memory handshake: a write is presented while mem_we=1 and completes on
    // the rising edge where mem_ready=1; until then addr/data stay unchanged.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        base_d     = base_q;
        vec_d      = vec_q;
        mem_we     = 1'b0;
        done       = 1'b0;
        block_pipe = 1'b0;
        case (state_q)
            IDLE: begin
                block_pipe = start;
                if (start) begin
                    base_d  = base_addr;
                    vec_d   = vector_in;
                    idx_d   = '0;
                    state_d = STORE;
                end
            end
            STORE: begin
                mem_we     = 1'b1;
                block_pipe = 1'b1;
                if (mem_ready) begin
                    idx_d = idx_q + IDX_W'(1);
                    if (idx_q == IDX_W'(LANES - 1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                // start is still the same instruction here, so it is not sampled.
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outside STORE the write port shows lane 0 at base_q so it stays deterministic.
    assign lane_sel  = (state_q == STORE) ? idx_q : '0;
    assign mem_addr  = base_q + {{(ADDR_WIDTH-IDX_W){1'b0}}, lane_sel};
    assign mem_wdata = lane_arr[lane_sel];
    assign state_dbg = state_q;

endmodule

// File: tb/tb_vector_store_handler.sv
// Scoreboard bench for vector_store_handler: stimulus pushes expected writes,
// a negedge monitor pops and compares every accepted write.
module tb_vector_store_handler;

    localparam int DW    = 16;
    localparam int LANES = 16;
    localparam int AW    = 19;
    localparam int EW    = AW + DW;

    logic                  clk;
    logic                  rst_n;
    logic                  start;
    logic [AW-1:0]         base_addr;
    logic [LANES*DW-1:0]   vector_in;
    logic                  mem_ready;
    logic                  mem_we;
    logic [AW-1:0]         mem_addr;
    logic [DW-1:0]         mem_wdata;
    logic                  block_pipe;
    logic                  done;
    logic [1:0]            state_dbg;

    logic [EW-1:0] exp_q[$];
    int checks;
    int failures;
    int done_cnt;

    vector_store_handler #(.DATA_WIDTH(DW), .LANES(LANES), .ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .base_addr  (base_addr),
        .vector_in  (vector_in),
        .mem_ready  (mem_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .block_pipe (block_pipe),
        .done       (done),
        .state_dbg  (state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        if (done === 1'b1) begin
            done_cnt++;
            check("done_with_we", 64'(mem_we), 64'd0);
        end
        if (mem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write actual=0x%0h/0x%0h expected=none", mem_addr, mem_wdata);
            end else if (mem_ready === 1'b1) begin
                check("write", 64'({mem_addr, mem_wdata}), 64'(exp_q.pop_front()));
            end else begin
                check("stalled_write", 64'({mem_addr, mem_wdata}), 64'(exp_q[0]));
            end
        end
    end

    function automatic logic [LANES*DW-1:0] make_vec(input logic [DW-1:0] dbase);
        logic [LANES*DW-1:0] v;
        for (int i = 0; i < LANES; i++) v[i*DW +: DW] = dbase + DW'(i);
        return v;
    endfunction

    task automatic push_lanes(input logic [AW-1:0] base, input logic [DW-1:0] dbase, input int n);
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        for (int i = 0; i < n; i++) begin
            a = base + AW'(i);
            d = dbase + DW'(i);
            exp_q.push_back({a, d});
        end
    endtask

    task automatic scramble();
        base_addr = AW'($urandom);
        for (int i = 0; i < LANES; i++) vector_in[i*DW +: DW] = DW'($urandom);
    endtask

    // driver: called just after a rising edge with the DUT in IDLE
    task automatic run_store(input logic [AW-1:0] base, input logic [DW-1:0] dbase,
                             input logic [LANES-1:0] stall_mask, input bit isolate,
                             input int exp_blocked);
        int blocked;
        int d0;
        blocked = 0;
        d0 = done_cnt;
        start = 1'b1;
        base_addr = base;
        vector_in = make_vec(dbase);
        mem_ready = 1'b1;
        push_lanes(base, dbase, LANES);
        @(negedge clk);
        if (block_pipe === 1'b1) blocked++;
        @(posedge clk);
        for (int i = 0; i < LANES; i++) begin
            if (stall_mask[i]) begin
                #1 mem_ready = 1'b0;
                if (isolate) scramble();
                @(negedge clk);
                if (block_pipe === 1'b1) blocked++;
                @(posedge clk);
            end
            #1 mem_ready = 1'b1;
            if (isolate) scramble();
            @(negedge clk);
            if (block_pipe === 1'b1) blocked++;
            @(posedge clk);
        end
        #1;
        if (!isolate) start = 1'b0;
        @(negedge clk);
        check("done_pulse", 64'(done), 64'd1);
        check("done_block_pipe", 64'(block_pipe), 64'd0);
        check("done_idle_addr", 64'({mem_addr, mem_wdata}), 64'({base, dbase}));
        check("blocked_cycles", 64'(blocked), 64'(exp_blocked));
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        check("no_retrigger", 64'({mem_we, block_pipe, done}), 64'd0);
        check("drained", 64'(exp_q.size()), 64'd0);
        check("one_done", 64'(done_cnt - d0), 64'd1);
        @(posedge clk);
        #1;
    endtask

    // stimulus
    initial begin
        int d0;
        checks = 0;
        failures = 0;
        done_cnt = 0;
        rst_n = 1'b0;
        start = 1'b1;
        mem_ready = 1'b1;
        base_addr = 19'h00100;
        vector_in = make_vec(16'hA000);

        @(posedge clk);
        @(negedge clk);
        check("rst_we_done", 64'({mem_we, done}), 64'd0);
        check("rst_state", 64'(state_dbg), 64'd0);
        check("rst_block_follows_start", 64'(block_pipe), 64'd1);
        check("rst_addr_data", 64'({mem_addr, mem_wdata}), 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // basic store, captured at the first edge out of reset
        run_store(19'h00100, 16'hA000, 16'h0000, 1'b0, 17);
        // backpressure on lanes 5 and 12
        run_store(19'h00100, 16'hA000, 16'h1020, 1'b0, 19);
        // address wrap
        run_store(19'h7FFFA, 16'h5550, 16'h0000, 1'b0, 17);
        // inputs scrambled after capture, start held through DONE
        run_store(19'h12340, 16'hC3C0, 16'h0001, 1'b1, 18);

        // reset after lane 7 accepted; lane 8 is presented during the reset cycle
        d0 = done_cnt;
        start = 1'b1;
        base_addr = 19'h00200;
        vector_in = make_vec(16'hB000);
        mem_ready = 1'b1;
        push_lanes(19'h00200, 16'hB000, 9);
        @(posedge clk);
        for (int i = 0; i < 8; i++) @(posedge clk);
        #1 rst_n = 1'b0;
        start = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rst_mid_quiet", 64'({mem_we, done, block_pipe}), 64'd0);
        end
        check("rst_mid_drained", 64'(exp_q.size()), 64'd0);
        check("rst_mid_no_done", 64'(done_cnt - d0), 64'd0);
        @(posedge clk);
        #1;
        run_store(19'h00300, 16'hD000, 16'h0000, 1'b0, 17);

        check("total_done", 64'(done_cnt), 64'd5);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
